// File: rtl/trig_request_sequencer_pkg.sv
// Shared types and constants for the trig request sequencer and its reducer.
package trig_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REDUCE,
        FOLD,
        LOOKUP,
        DONE
    } state_t;

    // Degree constants sized to hold a shifted 9-bit remainder during division.
    localparam logic [9:0] DEG_90  = 10'd90;
    localparam logic [9:0] DEG_180 = 10'd180;
    localparam logic [9:0] DEG_270 = 10'd270;
    localparam logic [9:0] DEG_360 = 10'd360;

    localparam logic OP_SIN = 1'b0;
    localparam logic OP_COS = 1'b1;

    localparam logic [31:0] ONE_Q = 32'h4000_0000;

endpackage

// File: rtl/trig_request_sequencer_if.sv
// Request, LUT and result signals of the trig request sequencer.
interface trig_request_sequencer_if #(
    parameter int ANGLE_W = 32,
    parameter int DATA_W  = 32
);
    logic               req_valid;
    logic               req_ready;
    logic [ANGLE_W-1:0] req_angle;
    logic               req_op;
    logic               lut_op_selector;
    logic [ANGLE_W-1:0] lut_angle;
    logic [DATA_W-1:0]  lut_value;
    logic               res_valid;
    logic               res_ready;
    logic [DATA_W-1:0]  res_value;

    modport slave (
        input  req_valid, req_angle, req_op, lut_value, res_ready,
        output req_ready, lut_op_selector, lut_angle, res_valid, res_value
    );

    modport master (
        output req_valid, req_angle, req_op, lut_value, res_ready,
        input  req_ready, lut_op_selector, lut_angle, res_valid, res_value
    );
endinterface

// File: rtl/trig_request_sequencer_mod360_reducer.sv
// Restoring divider by 360: one dividend bit per cycle, remainder only.
module mod360_reducer
    import trig_pkg::*;
#(
    parameter int ANGLE_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ANGLE_W-1:0] dividend,
    output logic               busy,
    output logic               done,
    output logic [8:0]         remainder
);
    localparam int CNT_W = $clog2(ANGLE_W + 1);

    logic [ANGLE_W-1:0] dvd_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [9:0]         trial;

    assign trial = {remainder, dvd_q[ANGLE_W-1]};

    // done is a single-cycle pulse coinciding with busy falling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_q     <= '0;
            cnt_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            remainder <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                dvd_q     <= dividend;
                remainder <= '0;
                cnt_q     <= CNT_W'(ANGLE_W);
                busy      <= 1'b1;
            end else if (busy) begin
                remainder <= (trial >= DEG_360) ? 9'(trial - DEG_360) : trial[8:0];
                dvd_q     <= dvd_q << 1;
                cnt_q     <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/trig_request_sequencer.sv
// Reduces a degree angle mod 360, folds it to 0..90 for the sin/cos LUT and signs the result.
module trig_request_sequencer
    import trig_pkg::*;
#(
    parameter int ANGLE_W = 32,
    parameter int DATA_W  = 32,
    parameter int FRAC_W  = 30
) (
    input  logic                      clk,
    input  logic                      rst_n,
    trig_request_sequencer_if.slave   bus
);
    state_t             state_q, state_d;
    logic               op_q;
    logic               red_start, red_busy, red_done;
    logic [8:0]         red_rem;
    logic [9:0]         a_c, fold_c;
    logic [1:0]         quad_c, quad_p1;
    logic [ANGLE_W-1:0] lut_angle_p1;
    logic               lut_op_p1;
    logic [DATA_W-1:0]  res_value_p2;

    // FRAC_W documents the value format only; the sign step is format-agnostic.
    logic unused_frac;
    assign unused_frac = (FRAC_W < DATA_W);

    function automatic logic is_negative(input logic [1:0] quad, input logic op);
        return (op == OP_COS) ? (quad == 2'd1 || quad == 2'd2) : quad[1];
    endfunction

    function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] mag, input logic neg);
        return neg ? ('0 - mag) : mag;
    endfunction

    assign red_start = (state_q == IDLE) && bus.req_valid;

    mod360_reducer #(.ANGLE_W(ANGLE_W)) u_reducer (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (red_start),
        .dividend  (bus.req_angle),
        .busy      (red_busy),
        .done      (red_done),
        .remainder (red_rem)
    );

    always_comb begin
        a_c    = {1'b0, red_rem};
        fold_c = a_c;
        quad_c = 2'd0;
        if (a_c < DEG_90) begin
            fold_c = a_c;
            quad_c = 2'd0;
        end else if (a_c < DEG_180) begin
            fold_c = DEG_180 - a_c;
            quad_c = 2'd1;
        end else if (a_c < DEG_270) begin
            fold_c = a_c - DEG_180;
            quad_c = 2'd2;
        end else begin
            fold_c = DEG_360 - a_c;
            quad_c = 2'd3;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req_valid) state_d = REDUCE;
            REDUCE:  if (red_done && !red_busy) state_d = FOLD;
            FOLD:    state_d = LOOKUP;
            LOOKUP:  state_d = DONE;
            DONE:    if (bus.res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_q         <= 1'b0;
            quad_p1      <= '0;
            lut_angle_p1 <= '0;
            lut_op_p1    <= 1'b0;
            res_value_p2 <= '0;
        end else begin
            state_q <= state_d;
            if (red_start) begin
                op_q <= bus.req_op;
            end
            // FOLD -> LOOKUP: folded angle and quadrant registered toward the LUT
            if (state_q == FOLD) begin
                quad_p1      <= quad_c;
                lut_angle_p1 <= ANGLE_W'(fold_c);
                lut_op_p1    <= op_q;
            end
            // LOOKUP -> DONE: LUT magnitude sampled and signed
            if (state_q == LOOKUP) begin
                res_value_p2 <= apply_sign(bus.lut_value, is_negative(quad_p1, lut_op_p1));
            end
        end
    end

    assign bus.req_ready       = (state_q == IDLE);
    assign bus.res_valid       = (state_q == DONE);
    assign bus.res_value       = res_value_p2;
    assign bus.lut_angle       = lut_angle_p1;
    assign bus.lut_op_selector = lut_op_p1;
endmodule

// File: tb/tb_trig_request_sequencer.sv
// Bench for trig_request_sequencer: vector table, directed corner sequences, random vs model.
module tb_trig_request_sequencer;
    import trig_pkg::*;

    localparam int LAT = 35;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    trig_request_sequencer_if #(.ANGLE_W(32), .DATA_W(32)) bus ();

    trig_request_sequencer #(.ANGLE_W(32), .DATA_W(32), .FRAC_W(30)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic        use_hash;
    logic [31:0] stub_fixed;

    function automatic logic [31:0] lut_hash(input logic [31:0] ang, input logic op);
        return (ang * 32'h9E37_79B9) ^ {op, 31'h2A5A_5A5A};
    endfunction

    always_comb bus.lut_value = use_hash ? lut_hash(bus.lut_angle, bus.lut_op_selector) : stub_fixed;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Reference: reduce, fold and sign directly from the quadrant rules.
    task automatic model(input logic [31:0] angle, input logic op,
                         output logic [31:0] fold, output logic neg);
        int unsigned a;
        a = angle % 32'd360;
        if (a <= 90)       fold = a;
        else if (a <= 180) fold = 180 - a;
        else if (a <= 270) fold = a - 180;
        else               fold = 360 - a;
        neg = (op == OP_COS) ? (a >= 90 && a < 270) : (a >= 180);
    endtask

    task automatic wait_result(output int cyc);
        cyc = 0;
        while (!bus.res_valid && cyc < 100) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic run_req(input string tag, input logic [31:0] angle, input logic op,
                           input logic [31:0] exp_ang, input logic [31:0] exp_res, input int rr_delay);
        int cyc;
        @(negedge clk);
        check({tag, " req_ready idle"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_angle = angle;
        bus.req_op    = op;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_angle = $urandom;
        bus.req_op    = ~op;
        wait_result(cyc);
        check({tag, " latency"}, 32'(cyc), 32'(LAT));
        check({tag, " lut_angle"}, bus.lut_angle, exp_ang);
        check({tag, " lut_op"}, 32'(bus.lut_op_selector), 32'(op));
        check({tag, " res_value"}, bus.res_value, exp_res);
        check({tag, " req_ready busy"}, 32'(bus.req_ready), 32'd0);
        repeat (rr_delay) @(negedge clk);
        bus.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.res_ready = 1'b0;
        check({tag, " res_valid drop"}, 32'(bus.res_valid), 32'd0);
        check({tag, " req_ready back"}, 32'(bus.req_ready), 32'd1);
    endtask

    typedef struct {
        logic [31:0] angle;
        logic        op;
        logic [31:0] stub;
        logic [31:0] exp_ang;
        logic [31:0] exp_res;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [31:0] fold, mag, exp_res, va, vb;
        logic        neg, bad_v, bad_d, bad_a, bad_r, seen;
        int          cyc;

        bus.req_valid = 1'b0;
        bus.req_angle = '0;
        bus.req_op    = OP_SIN;
        bus.res_ready = 1'b0;
        use_hash      = 1'b0;
        stub_fixed    = '0;

        vecs[0] = '{32'd30,         OP_SIN, 32'h2000_0000, 32'd30, 32'h2000_0000};
        vecs[1] = '{32'd210,        OP_COS, 32'h376C_F5D1, 32'd30, 32'hC893_0A2F};
        vecs[2] = '{32'd390,        OP_SIN, 32'h1234_5678, 32'd30, 32'h1234_5678};
        vecs[3] = '{32'hFFFF_FFFF,  OP_SIN, 32'h3DD3_C0D0, 32'd75, 32'hC22C_3F30};
        vecs[4] = '{32'd90,         OP_SIN, ONE_Q,         32'd90, 32'h4000_0000};
        vecs[5] = '{32'd180,        OP_SIN, 32'h0000_0000, 32'd0,  32'h0000_0000};
        vecs[6] = '{32'd270,        OP_SIN, ONE_Q,         32'd90, 32'hC000_0000};
        vecs[7] = '{32'd360,        OP_SIN, 32'h0000_0001, 32'd0,  32'h0000_0001};
        vecs[8] = '{32'd0,          OP_COS, ONE_Q,         32'd0,  32'h4000_0000};
        vecs[9] = '{32'd90,         OP_COS, 32'h0000_0005, 32'd90, 32'hFFFF_FFFB};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset req_ready", 32'(bus.req_ready), 32'd1);
        check("reset res_valid", 32'(bus.res_valid), 32'd0);
        check("reset res_value", bus.res_value, 32'd0);
        check("reset lut_angle", bus.lut_angle, 32'd0);
        check("reset lut_op", 32'(bus.lut_op_selector), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            stub_fixed = vecs[i].stub;
            run_req($sformatf("vec%0d", i), vecs[i].angle, vecs[i].op,
                    vecs[i].exp_ang, vecs[i].exp_res, i % 3);
        end

        // Abort in the twelfth REDUCE cycle
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_angle = 32'd123;
        bus.req_op    = OP_COS;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort req_ready", 32'(bus.req_ready), 32'd1);
        check("abort res_valid", 32'(bus.res_valid), 32'd0);
        check("abort res_value", bus.res_value, 32'd0);
        check("abort lut_angle", bus.lut_angle, 32'd0);
        check("abort lut_op", 32'(bus.lut_op_selector), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.res_valid || !bus.req_ready) seen = 1'b1;
        end
        check("abort no result", 32'(seen), 32'd0);
        stub_fixed = 32'h0ABC_DEF0;
        run_req("after abort", 32'd150, OP_SIN, 32'd30, 32'h0ABC_DEF0, 0);

        // Backpressure in DONE with an ignored request pulse
        use_hash = 1'b1;
        model(32'd210, OP_SIN, fold, neg);
        mag = lut_hash(fold, OP_SIN);
        exp_res = neg ? (32'd0 - mag) : mag;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_angle = 32'd210;
        bus.req_op    = OP_SIN;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        wait_result(cyc);
        check("bp latency", 32'(cyc), 32'(LAT));
        check("bp res_value", bus.res_value, exp_res);
        va = bus.res_value;
        vb = bus.lut_angle;
        bad_v = 1'b0; bad_d = 1'b0; bad_a = 1'b0; bad_r = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.req_valid = (i == 4);
            bus.req_angle = 32'd45;
            @(posedge clk);
            @(negedge clk);
            if (!bus.res_valid) bad_v = 1'b1;
            if (bus.res_value !== va) bad_d = 1'b1;
            if (bus.lut_angle !== vb) bad_a = 1'b1;
            if (bus.req_ready) bad_r = 1'b1;
        end
        bus.req_valid = 1'b0;
        check("bp res_valid held", 32'(bad_v), 32'd0);
        check("bp res_value held", 32'(bad_d), 32'd0);
        check("bp lut_angle held", 32'(bad_a), 32'd0);
        check("bp req_ready low", 32'(bad_r), 32'd0);
        bus.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.res_ready = 1'b0;
        check("bp released", 32'(bus.res_valid), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (!bus.req_ready) seen = 1'b1;
        end
        check("bp pulse ignored", 32'(seen), 32'd0);

        // Back-to-back with res_ready tied high
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_angle = 32'd45;
        bus.req_op    = OP_SIN;
        @(posedge clk);
        @(negedge clk);
        bus.req_angle = 32'd300;
        bus.req_op    = OP_COS;
        wait_result(cyc);
        check("b2b first latency", 32'(cyc), 32'(LAT));
        model(32'd45, OP_SIN, fold, neg);
        mag = lut_hash(fold, OP_SIN);
        check("b2b first res", bus.res_value, neg ? (32'd0 - mag) : mag);
        @(posedge clk);
        @(negedge clk);
        check("b2b idle gap", 32'(bus.req_ready), 32'd1);
        check("b2b first drop", 32'(bus.res_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("b2b second accepted", 32'(bus.req_ready), 32'd0);
        wait_result(cyc);
        check("b2b second latency", 32'(cyc), 32'(LAT));
        model(32'd300, OP_COS, fold, neg);
        mag = lut_hash(fold, OP_COS);
        check("b2b second lut_angle", bus.lut_angle, fold);
        check("b2b second res", bus.res_value, neg ? (32'd0 - mag) : mag);
        @(posedge clk);
        @(negedge clk);
        bus.res_ready = 1'b0;

        // Random requests against the reference model
        for (int i = 0; i < 30; i++) begin
            logic [31:0] ang;
            logic        op;
            ang = (i % 3 == 0) ? $urandom : 32'($urandom_range(0, 1000));
            op  = 1'($urandom_range(0, 1));
            model(ang, op, fold, neg);
            mag = lut_hash(fold, op);
            exp_res = neg ? (32'd0 - mag) : mag;
            run_req($sformatf("rnd%0d a=%0d op=%0d", i, ang, op), ang, op, fold, exp_res,
                    int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
